regfile_mips_2w2r: RTL and testbench

- Parametrised successor of the MIPS 32x32 register file: 2 combinational read ports and 2 byte-masked write ports.
- Adds an async active-low reset, a sequential post-reset clear sweep, and a per-register busy scoreboard for load/long-latency hazard detection.
- Sits in the decode stage: reads feed the ID/EX latch; write port A is driven by WB and write port B by the load/mul-div return path.

---
 rtl/regfile_pkg.sv | 28 ++
 rtl/regfile_scoreboard.sv | 54 +++++
 rtl/regfile_mips_2w2r.sv | 147 ++++++++++++++
 tb/tb_regfile_mips_2w2r.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the dual-write MIPS register file.
// Optional write-first forwarding is enabled by REGFILE_BYPASS_EN.
package regfile_pkg;

   typedef enum logic {
      INIT  = 1'b0,
      READY = 1'b1
   } state_e;

   localparam int unsigned REG_ZERO       = 0;
   localparam int unsigned MAX_DATA_WIDTH = 128;
   localparam int unsigned MAX_BE_WIDTH   = MAX_DATA_WIDTH / 8;

   // Replace each byte of old_data whose active-low enable is 0 with the byte from data.
   function automatic logic [MAX_DATA_WIDTH-1:0] merge_bytes(
      input logic [MAX_DATA_WIDTH-1:0] old_data,
      input logic [MAX_DATA_WIDTH-1:0] data,
      input logic [MAX_BE_WIDTH-1:0]   be_n
   );
      logic [MAX_DATA_WIDTH-1:0] res;
      res = old_data;
      for (int i = 0; i < int'(MAX_BE_WIDTH); i++) begin
         if (!be_n[i]) res[i*8 +: 8] = data[i*8 +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set on issue, cleared by any enabled write.
// With REGFILE_BYPASS_EN, lookups also see same-cycle clears.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_en,
   input  logic                  i_set_valid,
   input  logic [ADDR_WIDTH-1:0] i_set_addr,
   input  logic                  i_clr_a_valid,
   input  logic [ADDR_WIDTH-1:0] i_clr_a_addr,
   input  logic                  i_clr_b_valid,
   input  logic [ADDR_WIDTH-1:0] i_clr_b_addr,
   input  logic [ADDR_WIDTH-1:0] i_rs_addr,
   input  logic [ADDR_WIDTH-1:0] i_rt_addr,
   output logic                  o_rs_busy,
   output logic                  o_rt_busy
);

   localparam int unsigned DEPTH = 2**ADDR_WIDTH;

   logic [DEPTH-1:0] r_busy;
   logic [DEPTH-1:0] w_busy_nxt;
   logic [DEPTH-1:0] w_set_vec;
   logic [DEPTH-1:0] w_clr_vec;

   // Set has priority over clear on the same register.
   always_comb begin
      w_set_vec = '0;
      w_clr_vec = '0;
      if (i_en && i_set_valid && (i_set_addr != ADDR_WIDTH'(REG_ZERO)))
         w_set_vec[i_set_addr] = 1'b1;
      if (i_clr_a_valid) w_clr_vec[i_clr_a_addr] = 1'b1;
      if (i_clr_b_valid) w_clr_vec[i_clr_b_addr] = 1'b1;
      w_busy_nxt = (r_busy & ~w_clr_vec) | w_set_vec;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_busy <= '0;
      else        r_busy <= w_busy_nxt;
   end

`ifdef REGFILE_BYPASS_EN
   assign o_rs_busy = r_busy[i_rs_addr] & ~(w_clr_vec[i_rs_addr] & ~w_set_vec[i_rs_addr]);
   assign o_rt_busy = r_busy[i_rt_addr] & ~(w_clr_vec[i_rt_addr] & ~w_set_vec[i_rt_addr]);
`else
   assign o_rs_busy = r_busy[i_rs_addr];
   assign o_rt_busy = r_busy[i_rt_addr];
`endif

endmodule

// File: rtl/regfile_mips_2w2r.sv
// 2-read / 2-byte-masked-write register file with post-reset clear sweep and busy scoreboard.
// Define REGFILE_BYPASS_EN for write-first forwarding on the read ports.
module regfile_mips_2w2r
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] Rs_addr,
   input  logic [ADDR_WIDTH-1:0] Rt_addr,
   output logic [DATA_WIDTH-1:0] Rs_out,
   output logic [DATA_WIDTH-1:0] Rt_out,
   input  logic [ADDR_WIDTH-1:0] Wa_addr,
   input  logic [DATA_WIDTH-1:0] Wa_in,
   input  logic [BE_WIDTH-1:0]   Wa_Byte_w_en,
   input  logic [ADDR_WIDTH-1:0] Wb_addr,
   input  logic [DATA_WIDTH-1:0] Wb_in,
   input  logic [BE_WIDTH-1:0]   Wb_Byte_w_en,
   input  logic                  Iss_valid,
   input  logic [ADDR_WIDTH-1:0] Iss_addr,
   output logic                  Rs_busy,
   output logic                  Rt_busy,
   output logic                  ready
);

   localparam int unsigned DEPTH = 2**ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(REG_ZERO);

   state_e                  r_state;
   state_e                  w_state_nxt;
   logic [ADDR_WIDTH-1:0]   r_init_cnt;
   logic [ADDR_WIDTH-1:0]   w_init_cnt_nxt;
   logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

   logic                    w_ready;
   logic                    w_wa_en;
   logic                    w_wb_en;
   logic                    w_same_addr;
   logic [DATA_WIDTH-1:0]   w_merge_a;
   logic [DATA_WIDTH-1:0]   w_merge_b;
   logic [DATA_WIDTH-1:0]   w_merge_ab;
   logic [DATA_WIDTH-1:0]   w_rs_data;
   logic [DATA_WIDTH-1:0]   w_rt_data;
   logic                    w_rs_busy;
   logic                    w_rt_busy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= INIT;
         r_init_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_init_cnt <= w_init_cnt_nxt;
      end
   end

   // Clear sweep walks every address once, then parks in READY until reset.
   always_comb begin
      w_state_nxt    = r_state;
      w_init_cnt_nxt = r_init_cnt;
      case (r_state)
         INIT: begin
            w_init_cnt_nxt = ADDR_WIDTH'(r_init_cnt + 1'b1);
            if (r_init_cnt == LAST_ADDR) begin
               w_state_nxt    = READY;
               w_init_cnt_nxt = '0;
            end
         end
         READY:   w_state_nxt = READY;
         default: w_state_nxt = INIT;
      endcase
   end

   assign w_ready     = (r_state == READY);
   assign ready       = w_ready;
   assign w_wa_en     = w_ready && (Wa_addr != ZERO_ADDR) && (Wa_Byte_w_en != '1);
   assign w_wb_en     = w_ready && (Wb_addr != ZERO_ADDR) && (Wb_Byte_w_en != '1);
   assign w_same_addr = w_wa_en && w_wb_en && (Wa_addr == Wb_addr);

   assign w_merge_a  = DATA_WIDTH'(merge_bytes(MAX_DATA_WIDTH'(r_mem[Wa_addr]),
                                               MAX_DATA_WIDTH'(Wa_in),
                                               MAX_BE_WIDTH'(Wa_Byte_w_en)));
   assign w_merge_b  = DATA_WIDTH'(merge_bytes(MAX_DATA_WIDTH'(r_mem[Wb_addr]),
                                               MAX_DATA_WIDTH'(Wb_in),
                                               MAX_BE_WIDTH'(Wb_Byte_w_en)));
   assign w_merge_ab = DATA_WIDTH'(merge_bytes(MAX_DATA_WIDTH'(w_merge_a),
                                               MAX_DATA_WIDTH'(Wb_in),
                                               MAX_BE_WIDTH'(Wb_Byte_w_en)));

   // Storage is cleared by the sweep, not by reset; on a shared address B is layered over A.
   always_ff @(posedge clk) begin
      if (!w_ready) begin
         r_mem[r_init_cnt] <= '0;
      end else begin
         if (w_wa_en && !w_same_addr) r_mem[Wa_addr] <= w_merge_a;
         if (w_wb_en)                 r_mem[Wb_addr] <= w_same_addr ? w_merge_ab : w_merge_b;
      end
   end

   always_comb begin
      w_rs_data = r_mem[Rs_addr];
      w_rt_data = r_mem[Rt_addr];
`ifdef REGFILE_BYPASS_EN
      if (w_wa_en && (Wa_addr == Rs_addr))
         w_rs_data = DATA_WIDTH'(merge_bytes(MAX_DATA_WIDTH'(w_rs_data), MAX_DATA_WIDTH'(Wa_in),
                                             MAX_BE_WIDTH'(Wa_Byte_w_en)));
      if (w_wb_en && (Wb_addr == Rs_addr))
         w_rs_data = DATA_WIDTH'(merge_bytes(MAX_DATA_WIDTH'(w_rs_data), MAX_DATA_WIDTH'(Wb_in),
                                             MAX_BE_WIDTH'(Wb_Byte_w_en)));
      if (w_wa_en && (Wa_addr == Rt_addr))
         w_rt_data = DATA_WIDTH'(merge_bytes(MAX_DATA_WIDTH'(w_rt_data), MAX_DATA_WIDTH'(Wa_in),
                                             MAX_BE_WIDTH'(Wa_Byte_w_en)));
      if (w_wb_en && (Wb_addr == Rt_addr))
         w_rt_data = DATA_WIDTH'(merge_bytes(MAX_DATA_WIDTH'(w_rt_data), MAX_DATA_WIDTH'(Wb_in),
                                             MAX_BE_WIDTH'(Wb_Byte_w_en)));
`endif
   end

   assign Rs_out = w_ready ? w_rs_data : '0;
   assign Rt_out = w_ready ? w_rt_data : '0;

   regfile_scoreboard #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_scoreboard (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_en          (w_ready),
      .i_set_valid   (Iss_valid),
      .i_set_addr    (Iss_addr),
      .i_clr_a_valid (w_wa_en),
      .i_clr_a_addr  (Wa_addr),
      .i_clr_b_valid (w_wb_en),
      .i_clr_b_addr  (Wb_addr),
      .i_rs_addr     (Rs_addr),
      .i_rt_addr     (Rt_addr),
      .o_rs_busy     (w_rs_busy),
      .o_rt_busy     (w_rt_busy)
   );

   assign Rs_busy = w_ready & w_rs_busy;
   assign Rt_busy = w_ready & w_rt_busy;

endmodule

// File: tb/tb_regfile_mips_2w2r.sv
// Directed bench for regfile_mips_2w2r; expectations follow REGFILE_BYPASS_EN when defined.
module tb_regfile_mips_2w2r;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  Rs_addr, Rt_addr, Wa_addr, Wb_addr, Iss_addr;
   logic [31:0] Rs_out, Rt_out, Wa_in, Wb_in;
   logic [3:0]  Wa_Byte_w_en, Wb_Byte_w_en;
   logic        Iss_valid, Rs_busy, Rt_busy, ready;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   regfile_mips_2w2r dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .Rs_addr      (Rs_addr),
      .Rt_addr      (Rt_addr),
      .Rs_out       (Rs_out),
      .Rt_out       (Rt_out),
      .Wa_addr      (Wa_addr),
      .Wa_in        (Wa_in),
      .Wa_Byte_w_en (Wa_Byte_w_en),
      .Wb_addr      (Wb_addr),
      .Wb_in        (Wb_in),
      .Wb_Byte_w_en (Wb_Byte_w_en),
      .Iss_valid    (Iss_valid),
      .Iss_addr     (Iss_addr),
      .Rs_busy      (Rs_busy),
      .Rt_busy      (Rt_busy),
      .ready        (ready)
   );

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle;
      Wa_addr = '0; Wa_in = '0; Wa_Byte_w_en = '1;
      Wb_addr = '0; Wb_in = '0; Wb_Byte_w_en = '1;
      Iss_valid = 1'b0; Iss_addr = '0;
   endtask

   // Release reset, expect ready exactly after edge 32, then every register reads zero.
   task automatic test_sweep(input string tag);
      rst_n = 1'b1;
      for (int k = 1; k <= 32; k++) begin
         tick;
         #1;
         n_total++;
         if (ready !== (k == 32)) $display("FAIL %s_ready edge %0d: got %b expected %b", tag, k, ready, (k == 32));
         else n_pass++;
      end
      for (int a = 0; a < 32; a++) begin
         Rs_addr = 5'(a);
         Rt_addr = 5'(31 - a);
         #1;
         n_total++;
         if (Rs_out !== 32'h0 || Rt_out !== 32'h0)
            $display("FAIL %s_clear reg %0d: got %h/%h expected 00000000", tag, a, Rs_out, Rt_out);
         else n_pass++;
      end
   endtask

   task automatic test_reset;
      idle;
      rst_n = 1'b0;
      Rs_addr = 5'd5; Rt_addr = 5'd6;
      tick; tick;
      #1;
      n_total++;
      if (ready !== 1'b0 || Rs_out !== 32'h0 || Rt_out !== 32'h0 || Rs_busy !== 1'b0 || Rt_busy !== 1'b0)
         $display("FAIL reset_state: got ready=%b rs=%h rt=%h busy=%b%b expected 0 0 0 00",
                  ready, Rs_out, Rt_out, Rs_busy, Rt_busy);
      else n_pass++;
      test_sweep("reset");
   endtask

   task automatic test_byte_writes;
      Wa_addr = 5'd5; Wa_in = 32'h11223344; Wa_Byte_w_en = 4'b0000;
      tick;
      Wa_in = 32'hAABBCCDD; Wa_Byte_w_en = 4'b1010;
      tick;
      idle;
      Rs_addr = 5'd5;
      #1;
      n_total++;
      if (Rs_out !== 32'h11BB33DD) $display("FAIL byte_wa: got %h expected 11bb33dd", Rs_out);
      else n_pass++;
      Wb_addr = 5'd6; Wb_in = 32'h55667788; Wb_Byte_w_en = 4'b0000;
      tick;
      Wb_in = 32'hFFFFFFFF; Wb_Byte_w_en = 4'b0111;
      tick;
      idle;
      Rt_addr = 5'd6;
      #1;
      n_total++;
      if (Rt_out !== 32'hFF667788) $display("FAIL byte_wb: got %h expected ff667788", Rt_out);
      else n_pass++;
   endtask

   task automatic test_dual_port;
      Wa_addr = 5'd7; Wa_in = 32'h11111111; Wa_Byte_w_en = 4'b0000;
      Wb_addr = 5'd7; Wb_in = 32'h22222222; Wb_Byte_w_en = 4'b1100;
      tick;
      idle;
      Rs_addr = 5'd7;
      #1;
      n_total++;
      if (Rs_out !== 32'h11112222) $display("FAIL dual_conflict: got %h expected 11112222", Rs_out);
      else n_pass++;
      Wa_addr = 5'd8;  Wa_in = 32'hA5A5A5A5; Wa_Byte_w_en = 4'b0000;
      Wb_addr = 5'd10; Wb_in = 32'h5A5A5A5A; Wb_Byte_w_en = 4'b0000;
      tick;
      idle;
      Rs_addr = 5'd8; Rt_addr = 5'd10;
      #1;
      n_total++;
      if (Rs_out !== 32'hA5A5A5A5 || Rt_out !== 32'h5A5A5A5A)
         $display("FAIL dual_disjoint: got %h/%h expected a5a5a5a5/5a5a5a5a", Rs_out, Rt_out);
      else n_pass++;
      Wa_addr = 5'd0; Wa_in = 32'hFFFFFFFF; Wa_Byte_w_en = 4'b0000;
      Wb_addr = 5'd0; Wb_in = 32'hFFFFFFFF; Wb_Byte_w_en = 4'b0000;
      Rs_addr = 5'd0; Rt_addr = 5'd0;
      #1;
      n_total++;
      if (Rs_out !== 32'h0) $display("FAIL reg0_same_cycle: got %h expected 00000000", Rs_out);
      else n_pass++;
      tick;
      idle;
      #1;
      n_total++;
      if (Rs_out !== 32'h0 || Rt_out !== 32'h0) $display("FAIL reg0_write: got %h/%h expected 0/0", Rs_out, Rt_out);
      else n_pass++;
   endtask

   task automatic test_scoreboard;
      Rs_addr = 5'd9; Rt_addr = 5'd9;
      #1;
      n_total++;
      if (Rs_busy !== 1'b0) $display("FAIL sb_idle: got %b expected 0", Rs_busy);
      else n_pass++;
      Iss_valid = 1'b1; Iss_addr = 5'd9;
      tick;
      idle;
      #1;
      n_total++;
      if (Rs_busy !== 1'b1 || Rt_busy !== 1'b1) $display("FAIL sb_set: got %b%b expected 11", Rs_busy, Rt_busy);
      else n_pass++;
      Iss_valid = 1'b1; Iss_addr = 5'd9;
      Wb_addr = 5'd9; Wb_in = 32'h00000099; Wb_Byte_w_en = 4'b0000;
      tick;
      idle;
      #1;
      n_total++;
      if (Rs_busy !== 1'b1 || Rt_out !== 32'h00000099)
         $display("FAIL sb_set_wins: got busy=%b data=%h expected 1 00000099", Rs_busy, Rt_out);
      else n_pass++;
      Wa_addr = 5'd9; Wa_in = 32'h0; Wa_Byte_w_en = 4'b1110;
      tick;
      idle;
      #1;
      n_total++;
      if (Rs_busy !== 1'b0) $display("FAIL sb_clear: got %b expected 0", Rs_busy);
      else n_pass++;
      Iss_valid = 1'b1; Iss_addr = 5'd0; Rs_addr = 5'd0;
      tick;
      idle;
      #1;
      n_total++;
      if (Rs_busy !== 1'b0) $display("FAIL sb_reg0: got %b expected 0", Rs_busy);
      else n_pass++;
      Iss_valid = 1'b1; Iss_addr = 5'd11; Rs_addr = 5'd11;
      tick;
      idle;
      Wa_addr = 5'd11; Wa_Byte_w_en = 4'b1111;
      tick;
      idle;
      #1;
      n_total++;
      if (Rs_busy !== 1'b1) $display("FAIL sb_no_be: got %b expected 1", Rs_busy);
      else n_pass++;
      Wb_addr = 5'd11; Wb_in = 32'h0; Wb_Byte_w_en = 4'b0000;
      #1;
      n_total++;
      if (Rs_busy !== !BYP) $display("FAIL sb_clear_same_cycle: got %b expected %b", Rs_busy, !BYP);
      else n_pass++;
      tick;
      idle;
      #1;
      n_total++;
      if (Rs_busy !== 1'b0) $display("FAIL sb_clear_b: got %b expected 0", Rs_busy);
      else n_pass++;
   endtask

   task automatic test_bypass;
      logic [31:0] exp;
      Wa_addr = 5'd3; Wa_in = 32'h33333333; Wa_Byte_w_en = 4'b0000;
      tick;
      idle;
      Rt_addr = 5'd3;
      Wa_addr = 5'd3; Wa_in = 32'hDEADBEEF; Wa_Byte_w_en = 4'b0000;
      #1;
      exp = BYP ? 32'hDEADBEEF : 32'h33333333;
      n_total++;
      if (Rt_out !== exp) $display("FAIL bypass_a: got %h expected %h", Rt_out, exp);
      else n_pass++;
      tick;
      idle;
      #1;
      n_total++;
      if (Rt_out !== 32'hDEADBEEF) $display("FAIL bypass_after: got %h expected deadbeef", Rt_out);
      else n_pass++;
      Wa_addr = 5'd3; Wa_in = 32'h11111111; Wa_Byte_w_en = 4'b0000;
      Wb_addr = 5'd3; Wb_in = 32'h22222222; Wb_Byte_w_en = 4'b1100;
      #1;
      exp = BYP ? 32'h11112222 : 32'hDEADBEEF;
      n_total++;
      if (Rt_out !== exp) $display("FAIL bypass_ab: got %h expected %h", Rt_out, exp);
      else n_pass++;
      tick;
      idle;
   endtask

   task automatic test_midop_reset;
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      repeat (10) tick;
      rst_n = 1'b0;
      Rs_addr = 5'd5;
      #1;
      n_total++;
      if (ready !== 1'b0 || Rs_out !== 32'h0) $display("FAIL midsweep_reset: got ready=%b rs=%h expected 0 0", ready, Rs_out);
      else n_pass++;
      tick;
      test_sweep("midsweep");
      Wa_addr = 5'd12; Wa_in = 32'hCAFEF00D; Wa_Byte_w_en = 4'b0000;
      tick;
      idle;
      Iss_valid = 1'b1; Iss_addr = 5'd12;
      tick;
      Iss_addr = 5'd13;
      tick;
      idle;
      Rs_addr = 5'd12; Rt_addr = 5'd13;
      #1;
      n_total++;
      if (Rs_busy !== 1'b1 || Rt_busy !== 1'b1 || Rs_out !== 32'hCAFEF00D)
         $display("FAIL ready_prefill: got busy=%b%b rs=%h expected 11 cafef00d", Rs_busy, Rt_busy, Rs_out);
      else n_pass++;
      rst_n = 1'b0;
      #1;
      n_total++;
      if (ready !== 1'b0 || Rs_busy !== 1'b0 || Rt_busy !== 1'b0 || Rs_out !== 32'h0)
         $display("FAIL ready_reset: got ready=%b busy=%b%b rs=%h expected 0 00 0", ready, Rs_busy, Rt_busy, Rs_out);
      else n_pass++;
      tick;
      test_sweep("ready_reset");
      Rs_addr = 5'd12; Rt_addr = 5'd13;
      #1;
      n_total++;
      if (Rs_busy !== 1'b0 || Rt_busy !== 1'b0) $display("FAIL busy_after_reset: got %b%b expected 00", Rs_busy, Rt_busy);
      else n_pass++;
   endtask

   initial begin
      idle;
      rst_n = 1'b0;
      Rs_addr = '0;
      Rt_addr = '0;
      test_reset;
      test_byte_writes;
      test_dual_port;
      test_scoreboard;
      test_bypass;
      test_midop_reset;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
